axi4_chan_buffer: RTL and testbench

- Parametrised buffer for one AXI4 channel (AW, W, B, AR or R), carrying the channel payload as an opaque packed vector.
- Three selectable modes: pass-through, cut-through FIFO, and burst-aware store-and-forward.
- Inserted between an `axi_interface` master and slave to break timing paths, absorb backpressure, or present only complete bursts (W/R) to the downstream side.
- Instantiated once per channel, so width and depth are set independently for each channel.

---
 rtl/axi4_pkg.sv | 64 ++++++
 rtl/axi4_chan_buffer.sv | 104 ++++++++++
 tb/tb_axi4_chan_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 types: channel field types, packed channel payloads and
// the buffering modes offered by axi4_chan_buffer.
package axi4_pkg;

    typedef logic [3:0]  axi_id_t;
    typedef logic [31:0] axi_addr_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [63:0] axi_data_t;
    typedef logic [7:0]  axi_strb_t;
    typedef logic [1:0]  axi_resp_t;

    typedef enum logic [1:0] {
        BUF_PASS,
        BUF_FIFO,
        BUF_SAF
    } buf_mode_e;

    typedef struct packed {
        axi_id_t    id;
        axi_addr_t  addr;
        axi_len_t   len;
        axi_size_t  size;
        axi_burst_t burst;
    } axi_aw_chan_t;

    // last sits in the LSB so the store-and-forward mode can find it at bit 0
    typedef struct packed {
        axi_data_t data;
        axi_strb_t strb;
        logic      last;
    } axi_w_chan_t;

    typedef struct packed {
        axi_id_t   id;
        axi_resp_t resp;
    } axi_b_chan_t;

    typedef struct packed {
        axi_id_t    id;
        axi_addr_t  addr;
        axi_len_t   len;
        axi_size_t  size;
        axi_burst_t burst;
    } axi_ar_chan_t;

    typedef struct packed {
        axi_id_t   id;
        axi_data_t data;
        axi_resp_t resp;
        logic      last;
    } axi_r_chan_t;

    localparam int AXI_AW_WIDTH = $bits(axi_aw_chan_t);
    localparam int AXI_W_WIDTH  = $bits(axi_w_chan_t);
    localparam int AXI_B_WIDTH  = $bits(axi_b_chan_t);
    localparam int AXI_AR_WIDTH = $bits(axi_ar_chan_t);
    localparam int AXI_R_WIDTH  = $bits(axi_r_chan_t);

    localparam int AXI_W_LAST_IDX = 0;
    localparam int AXI_R_LAST_IDX = 0;

endpackage

// File: rtl/axi4_chan_buffer.sv
// Single AXI4 channel buffer: wires, a cut-through FIFO, or a FIFO that only
// presents complete bursts downstream (store-and-forward).
module axi4_chan_buffer
    import axi4_pkg::*;
#(
    parameter int        WIDTH    = 64,
    parameter int        DEPTH    = 2,
    parameter buf_mode_e MODE     = BUF_FIFO,
    parameter int        LAST_IDX = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_payload,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_payload,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] bursts
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (MODE == BUF_PASS) begin : g_pass
            assign m_valid   = s_valid;
            assign s_ready   = m_ready;
            assign m_payload = s_payload;
            assign count     = '0;
            assign bursts    = '0;
        end else begin : g_buf
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]    wr_ptr, rd_ptr;
            logic [CW-1:0]    cnt;
            logic             push, pop;

            // s_ready depends on state only, so full blocks a push even during a pop
            assign s_ready   = !rst && (cnt != CW'(DEPTH));
            assign push      = s_valid && s_ready;
            assign pop       = m_valid && m_ready;
            assign m_payload = mem[rd_ptr];
            assign count     = cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (push)
                        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                    if (pop)
                        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                    case ({push, pop})
                        2'b10:   cnt <= cnt + 1'b1;
                        2'b01:   cnt <= cnt - 1'b1;
                        default: cnt <= cnt;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (push)
                    mem[wr_ptr] <= s_payload;
            end

            if (MODE == BUF_SAF) begin : g_saf
                logic [CW-1:0] nbursts;
                logic          draining;
                logic          push_last, pop_last;

                assign push_last = push && s_payload[LAST_IDX];
                assign pop_last  = pop && m_payload[LAST_IDX];
                assign bursts    = nbursts;
                // Full without a complete burst releases the head; draining then
                // keeps m_valid up until the oversized burst's last beat leaves.
                assign m_valid   = (nbursts != '0) || (cnt == CW'(DEPTH)) ||
                                   (draining && cnt != '0);

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        nbursts  <= '0;
                        draining <= 1'b0;
                    end else begin
                        if (push_last && !pop_last)
                            nbursts <= nbursts + 1'b1;
                        else if (pop_last && !push_last)
                            nbursts <= nbursts - 1'b1;
                        if (pop_last)
                            draining <= 1'b0;
                        else if (pop && nbursts == '0)
                            draining <= 1'b1;
                    end
                end
            end else begin : g_fifo
                assign m_valid = (cnt != '0);
                assign bursts  = '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_axi4_chan_buffer.sv
// Directed bench for axi4_chan_buffer: five instances in different modes,
// checked every cycle against a queue model plus literal expectations.
module tb_axi4_chan_buffer;
    import axi4_pkg::*;

    localparam int NI = 5;
    localparam int MODE_I [NI] = '{BUF_FIFO, BUF_FIFO, BUF_SAF, BUF_SAF, BUF_PASS};
    localparam int DEPTHS [NI] = '{4, 2, 8, 4, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0]          s_valid = '0, s_ready, m_valid, m_ready = '0;
    logic [NI-1:0][7:0]     s_pl = '0, m_pl;
    logic [NI-1:0][3:0]     cnt_o, bur_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq  [NI][$];
    logic [7:0] got [NI][$];
    bit         started [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int D  = DEPTHS[g];
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c, b;
        axi4_chan_buffer #(
            .WIDTH(8), .DEPTH(D), .MODE(buf_mode_e'(MODE_I[g])), .LAST_IDX(0)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_payload(s_pl[g]),
            .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_payload(m_pl[g]),
            .count(c), .bursts(b)
        );
        assign cnt_o[g] = 4'(c);
        assign bur_o[g] = 4'(b);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: each buffer is a queue of beats. In SAF mode the head is visible
    // once a whole burst is held, the queue is full, or the head burst has
    // already started leaving.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            int sz, nl;
            bit ev, es;
            logic [7:0] ep, b;
            if (rst) begin
                mq[g].delete();
                started[g] = 1'b0;
            end
            sz = mq[g].size();
            nl = 0;
            for (int k = 0; k < sz; k++)
                if (mq[g][k][0]) nl++;
            if (MODE_I[g] == BUF_PASS) begin
                ev = s_valid[g]; es = m_ready[g]; ep = s_pl[g]; sz = 0; nl = 0;
            end else begin
                es = !rst && sz != DEPTHS[g];
                if (MODE_I[g] == BUF_FIFO) begin
                    ev = sz != 0; nl = 0;
                end else
                    ev = nl != 0 || sz == DEPTHS[g] || (started[g] && sz != 0);
                if (rst) ev = 1'b0;
                ep = (sz != 0) ? mq[g][0] : 8'h00;
            end
            chk($sformatf("m_valid[%0d]", g), int'(m_valid[g]), int'(ev));
            chk($sformatf("s_ready[%0d]", g), int'(s_ready[g]), int'(es));
            chk($sformatf("count[%0d]", g), int'(cnt_o[g]), sz);
            chk($sformatf("bursts[%0d]", g), int'(bur_o[g]), nl);
            if (ev)
                chk($sformatf("m_payload[%0d]", g), int'(m_pl[g]), int'(ep));
            if (MODE_I[g] != BUF_PASS && m_valid[g] && m_ready[g])
                got[g].push_back(m_pl[g]);
            if (!rst && MODE_I[g] != BUF_PASS) begin
                if (ev && m_ready[g]) begin
                    b = mq[g].pop_front();
                    started[g] = !b[0];
                end
                if (s_valid[g] && es)
                    mq[g].push_back(s_pl[g]);
            end
        end
    end

    logic [7:0] v4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] b3 [3] = '{8'h10, 8'h20, 8'h31};
    logic [7:0] b6 [6] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0D};

    initial begin
        int n, i, base;
        bit seen;

        // reset
        tick(); tick();
        @(negedge clk);
        chk("rst_m_valid", int'(m_valid[0]), 0);
        chk("rst_s_ready", int'(s_ready[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_s_ready", int'(s_ready[0]), 1);
        chk("release_count", int'(cnt_o[0]), 0);
        tick();

        // FIFO depth 4: fill then drain in order
        for (int k = 0; k < 3; k++) begin
            s_valid[0] = 1'b1; s_pl[0] = v4[k];
            tick();
        end
        s_valid[0] = 1'b0;
        @(negedge clk);
        chk("fifo4_count3", int'(cnt_o[0]), 3);
        chk("fifo4_ready3", int'(s_ready[0]), 1);
        tick();
        s_valid[0] = 1'b1; s_pl[0] = v4[3];
        tick();
        s_valid[0] = 1'b0;
        @(negedge clk);
        chk("fifo4_count4", int'(cnt_o[0]), 4);
        chk("fifo4_full_ready", int'(s_ready[0]), 0);
        tick();
        m_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        m_ready[0] = 1'b0;
        chk("fifo4_pops", got[0].size(), 4);
        for (int k = 0; k < 4 && k < got[0].size(); k++)
            chk($sformatf("fifo4_order%0d", k), int'(got[0][k]), int'(v4[k]));

        // reset with three entries held
        for (int k = 0; k < 3; k++) begin
            s_valid[0] = 1'b1; s_pl[0] = 8'hA1 + 8'(k);
            tick();
        end
        s_valid[0] = 1'b0;
        base = got[0].size();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_count", int'(cnt_o[0]), 0);
        chk("midrst_m_valid", int'(m_valid[0]), 0);
        tick();
        rst = 1'b0;
        m_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        m_ready[0] = 1'b0;
        chk("midrst_no_stale", got[0].size(), base);

        // FIFO depth 2: 100 beats streamed back to back
        m_ready[1] = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            s_valid[1] = (c < 100);
            s_pl[1] = 8'(c);
            @(negedge clk);
            if (c == 50) chk("fifo2_steady_count", int'(cnt_o[1]), 1);
            tick();
        end
        s_valid[1] = 1'b0; m_ready[1] = 1'b0;
        chk("fifo2_total", got[1].size(), 100);
        for (int k = 0; k < got[1].size(); k++)
            if (got[1][k] != 8'(k)) chk($sformatf("fifo2_beat%0d", k), int'(got[1][k]), k);

        // SAF depth 8: 3-beat burst held until its last beat is in
        for (int k = 0; k < 3; k++) begin
            s_valid[2] = 1'b1; s_pl[2] = b3[k];
            @(negedge clk);
            chk($sformatf("saf8_hold%0d", k), int'(m_valid[2]), 0);
            tick();
        end
        s_valid[2] = 1'b0;
        @(negedge clk);
        chk("saf8_release", int'(m_valid[2]), 1);
        chk("saf8_bursts1", int'(bur_o[2]), 1);
        tick();
        m_ready[2] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        m_ready[2] = 1'b0;
        @(negedge clk);
        chk("saf8_bursts0", int'(bur_o[2]), 0);
        chk("saf8_got", got[2].size(), 3);
        for (int k = 0; k < 3 && k < got[2].size(); k++)
            chk($sformatf("saf8_order%0d", k), int'(got[2][k]), int'(b3[k]));
        tick();

        // SAF depth 4: 6-beat burst overflows and drains through
        m_ready[3] = 1'b1;
        i = 0; n = 0; seen = 1'b0;
        while (got[3].size() < 6 && n < 60) begin
            s_valid[3] = (i < 6);
            s_pl[3] = b6[(i < 6) ? i : 0];
            @(negedge clk);
            if (m_valid[3] && !seen) begin
                seen = 1'b1;
                chk("saf4_rise_count", int'(cnt_o[3]), 4);
            end
            if (s_valid[3] && s_ready[3]) i++;
            n++;
            tick();
        end
        s_valid[3] = 1'b0; m_ready[3] = 1'b0;
        chk("saf4_got", got[3].size(), 6);
        for (int k = 0; k < 6 && k < got[3].size(); k++)
            chk($sformatf("saf4_order%0d", k), int'(got[3][k]), int'(b6[k]));
        s_valid[3] = 1'b1; s_pl[3] = 8'h40;
        tick();
        s_valid[3] = 1'b0;
        @(negedge clk);
        chk("saf4_draining_cleared", int'(m_valid[3]), 0);
        tick();

        // PASS: random handshake toggling
        for (int k = 0; k < 20; k++) begin
            s_valid[4] = 1'($urandom_range(0, 1));
            m_ready[4] = 1'($urandom_range(0, 1));
            s_pl[4] = 8'($urandom);
            @(negedge clk);
            chk("pass_ready", int'(s_ready[4]), int'(m_ready[4]));
            chk("pass_payload", int'(m_pl[4]), int'(s_pl[4]));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
